// File: rtl/tank_world_pkg.sv
// Shared constants and the coin attribute word layout for the tank arena.
package tank_world_pkg;

  localparam int unsigned COIN_BASE_DEF  = 2058;
  localparam int unsigned SCORE_BASE_DEF = 2063;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 3;
  localparam int unsigned VALUE_W = 4;
  localparam int unsigned RSVD_W  = 4;

  // Bit 0 is valid; reserved nibble sits at [31:28] and always reads back as zero.
  typedef struct packed {
    logic [RSVD_W-1:0]  rsvd;
    logic [VALUE_W-1:0] value;
    logic [FRAME_W-1:0] frame;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic               valid;
  } coin_attr_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [VALUE_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/coin_hit_detect.sv
// Combinational coin vs. tank hitbox compare; lowest tank index wins when several overlap.
module coin_hit_detect
  import tank_world_pkg::*;
#(
  parameter int unsigned TANK_NUM = 2,
  parameter int unsigned TANK_W   = 32,
  parameter int unsigned TANK_H   = 32
) (
  input  logic                             valid_i,
  input  logic [COORD_W-1:0]               x_i,
  input  logic [COORD_W-1:0]               y_i,
  input  logic [TANK_NUM-1:0][COORD_W-1:0] tank_x_i,
  input  logic [TANK_NUM-1:0][COORD_W-1:0] tank_y_i,
  output logic                             hit_o,
  output logic [2:0]                       tank_o
);

  localparam logic [COORD_W:0] BOX_W = (COORD_W + 1)'(TANK_W);
  localparam logic [COORD_W:0] BOX_H = (COORD_W + 1)'(TANK_H);

  // One extra bit so a tank near the right/bottom edge does not wrap its box.
  logic [COORD_W:0] cx, cy;
  assign cx = {1'b0, x_i};
  assign cy = {1'b0, y_i};

  always_comb begin
    hit_o  = 1'b0;
    tank_o = '0;
    for (int t = int'(TANK_NUM) - 1; t >= 0; t--) begin
      if (valid_i &&
          (cx >= {1'b0, tank_x_i[t]}) && (cx < ({1'b0, tank_x_i[t]} + BOX_W)) &&
          (cy >= {1'b0, tank_y_i[t]}) && (cy < ({1'b0, tank_y_i[t]} + BOX_H))) begin
        hit_o  = 1'b1;
        tank_o = 3'(t);
      end
    end
  end

endmodule

// File: rtl/coin_engine.sv
// Coin register file, round-robin tank/coin collection with saturating scores, respawn timers
// and frame animation; collect_* outputs are registered one cycle after the hit.
module coin_engine
  import tank_world_pkg::*;
#(
  parameter int unsigned COIN_NUM    = 3,
  parameter int unsigned TANK_NUM    = 2,
  parameter int unsigned TANK_W      = 32,
  parameter int unsigned TANK_H      = 32,
  parameter int unsigned FRAME_NUM   = 8,
  parameter int unsigned ANIM_DIV    = 2**21,
  parameter int unsigned RESPAWN_CYC = 2**26,
  parameter int unsigned COIN_BASE   = COIN_BASE_DEF,
  parameter int unsigned SCORE_BASE  = SCORE_BASE_DEF
) (
  input  logic                             CLK,
  input  logic                             Reset,
  input  logic                             AVL_WRITE,
  input  logic [11:0]                      AVL_ADDR,
  input  logic [31:0]                      AVL_WRITEDATA,
  input  logic                             respawn_en,
  input  logic [TANK_NUM-1:0][COORD_W-1:0] tank_x,
  input  logic [TANK_NUM-1:0][COORD_W-1:0] tank_y,
  output logic [TANK_NUM-1:0][31:0]        score_attr_reg,
  output logic [COIN_NUM-1:0][31:0]        coin_attr_reg_out,
  output logic                             collect_pulse,
  output logic [2:0]                       collect_tank,
  output logic [3:0]                       collect_coin
);

  localparam logic [FRAME_W-1:0] FRAME_MASK = FRAME_W'(FRAME_NUM - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [31:0]        PRE_LAST   = 32'(ANIM_DIV - 1);
  localparam logic [31:0]        TMR_LOAD   = 32'(RESPAWN_CYC - 1);
  localparam logic [3:0]         SC_LAST    = 4'(COIN_NUM - 1);

  coin_attr_t [COIN_NUM-1:0] coin_q, coin_d;
  logic [COIN_NUM-1:0][31:0] timer_q, timer_d;
  logic [COIN_NUM-1:0]       armed_q, armed_d;
  logic [TANK_NUM-1:0][31:0] score_q, score_d;
  logic [31:0]               pre_q, pre_d;
  logic [3:0]                sc_q, sc_d;
  logic                      pulse_q, pulse_d;
  logic [2:0]                ctank_q, ctank_d;
  logic [3:0]                ccoin_q, ccoin_d;

  logic                      cur_valid;
  logic [COORD_W-1:0]        cur_x, cur_y;
  logic [VALUE_W-1:0]        cur_value;
  logic                      hit, collect, anim_tick;
  logic [2:0]                hit_tank;
  coin_attr_t                wr_coin;

  assign wr_coin   = coin_attr_t'(AVL_WRITEDATA & 32'h0FFF_FFFF);
  assign anim_tick = (pre_q == PRE_LAST);
  // A bus write in the hit cycle defers the collection; the held pointer rescans the coin.
  assign collect   = hit && !AVL_WRITE;

  always_comb begin
    cur_valid = 1'b0;
    cur_x     = '0;
    cur_y     = '0;
    cur_value = '0;
    for (int c = 0; c < int'(COIN_NUM); c++) begin
      if (sc_q == 4'(c)) begin
        cur_valid = coin_q[c].valid;
        cur_x     = coin_q[c].x;
        cur_y     = coin_q[c].y;
        cur_value = coin_q[c].value;
      end
    end
  end

  coin_hit_detect #(
    .TANK_NUM (TANK_NUM),
    .TANK_W   (TANK_W),
    .TANK_H   (TANK_H)
  ) u_hit (
    .valid_i  (cur_valid),
    .x_i      (cur_x),
    .y_i      (cur_y),
    .tank_x_i (tank_x),
    .tank_y_i (tank_y),
    .hit_o    (hit),
    .tank_o   (hit_tank)
  );

  always_comb begin
    pre_d   = anim_tick ? '0 : pre_q + 32'd1;
    sc_d    = (hit && AVL_WRITE) ? sc_q : ((sc_q == SC_LAST) ? 4'd0 : sc_q + 4'd1);
    pulse_d = collect;
    ctank_d = collect ? hit_tank : 3'd0;
    ccoin_d = collect ? sc_q : 4'd0;

    score_d = score_q;
    for (int t = 0; t < int'(TANK_NUM); t++) begin
      if (collect && (hit_tank == 3'(t)))
        score_d[t] = sat_add(score_q[t], cur_value);
      if (AVL_WRITE && (AVL_ADDR == 12'(SCORE_BASE + t)))
        score_d[t] = AVL_WRITEDATA;
    end

    coin_d  = coin_q;
    timer_d = timer_q;
    armed_d = armed_q;
    for (int c = 0; c < int'(COIN_NUM); c++) begin
      if (anim_tick && coin_q[c].valid)
        coin_d[c].frame = (coin_q[c].frame + FRAME_ONE) & FRAME_MASK;
      if (!coin_q[c].valid && armed_q[c] && respawn_en) begin
        if (timer_q[c] == 32'd0) begin
          coin_d[c].valid = 1'b1;
          armed_d[c]      = 1'b0;
        end else begin
          timer_d[c] = timer_q[c] - 32'd1;
        end
      end
      if (collect && (sc_q == 4'(c))) begin
        coin_d[c]       = coin_q[c];
        coin_d[c].valid = 1'b0;
        armed_d[c]      = 1'b1;
        timer_d[c]      = TMR_LOAD;
      end
      if (AVL_WRITE && (AVL_ADDR == 12'(COIN_BASE + c))) begin
        coin_d[c]  = wr_coin;
        armed_d[c] = 1'b0;
        timer_d[c] = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      coin_q  <= '0;
      timer_q <= '0;
      armed_q <= '0;
      score_q <= '0;
      pre_q   <= '0;
      sc_q    <= '0;
      pulse_q <= 1'b0;
      ctank_q <= '0;
      ccoin_q <= '0;
    end else begin
      coin_q  <= coin_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      score_q <= score_d;
      pre_q   <= pre_d;
      sc_q    <= sc_d;
      pulse_q <= pulse_d;
      ctank_q <= ctank_d;
      ccoin_q <= ccoin_d;
    end
  end

  assign score_attr_reg    = score_q;
  assign coin_attr_reg_out = coin_q;
  assign collect_pulse     = pulse_q;
  assign collect_tank      = ctank_q;
  assign collect_coin      = ccoin_q;

endmodule

// File: tb/tb_coin_engine.sv
// Directed bench for coin_engine: collection, tie-break, hitbox edges, saturation, respawn,
// write-suppressed collection, mid-run reset and animation.
module tb_coin_engine;

  localparam int COIN_NUM  = 3;
  localparam int TANK_NUM  = 2;
  localparam int COIN_BASE = 2058;
  localparam int SCORE_BASE = 2063;

  logic                        CLK = 1'b0;
  logic                        Reset = 1'b1;
  logic                        AVL_WRITE = 1'b0;
  logic [11:0]                 AVL_ADDR = '0;
  logic [31:0]                 AVL_WRITEDATA = '0;
  logic                        respawn_en = 1'b0;
  logic [TANK_NUM-1:0][9:0]    tank_x;
  logic [TANK_NUM-1:0][9:0]    tank_y;
  logic [TANK_NUM-1:0][31:0]   score_attr_reg;
  logic [COIN_NUM-1:0][31:0]   coin_attr_reg_out;
  logic                        collect_pulse;
  logic [2:0]                  collect_tank;
  logic [3:0]                  collect_coin;

  int n_cmp = 0;
  int n_err = 0;

  coin_engine #(
    .COIN_NUM    (COIN_NUM),
    .TANK_NUM    (TANK_NUM),
    .TANK_W      (32),
    .TANK_H      (32),
    .FRAME_NUM   (8),
    .ANIM_DIV    (256),
    .RESPAWN_CYC (16),
    .COIN_BASE   (COIN_BASE),
    .SCORE_BASE  (SCORE_BASE)
  ) dut (
    .CLK               (CLK),
    .Reset             (Reset),
    .AVL_WRITE         (AVL_WRITE),
    .AVL_ADDR          (AVL_ADDR),
    .AVL_WRITEDATA     (AVL_WRITEDATA),
    .respawn_en        (respawn_en),
    .tank_x            (tank_x),
    .tank_y            (tank_y),
    .score_attr_reg    (score_attr_reg),
    .coin_attr_reg_out (coin_attr_reg_out),
    .collect_pulse     (collect_pulse),
    .collect_tank      (collect_tank),
    .collect_coin      (collect_coin)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mkcoin(input logic v, input int x, input int y,
                                         input int f, input int val);
    return {4'b0, 4'(val), 3'(f), 10'(y), 10'(x), v};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic avl_wr(input int addr, input logic [31:0] data);
    AVL_WRITE     = 1'b1;
    AVL_ADDR      = 12'(addr);
    AVL_WRITEDATA = data;
    tick();
    AVL_WRITE     = 1'b0;
  endtask

  task automatic wait_pulse(input int limit, output int waited);
    waited = 0;
    while (collect_pulse !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (collect_pulse === 1'b1) cnt++;
    end
  endtask

  initial begin
    int w;
    int cnt;
    tank_x[0] = 10'd80;  tank_y[0] = 10'd90;
    tank_x[1] = 10'd500; tank_y[1] = 10'd500;

    // Reset state
    tick(); tick();
    chk("rst_score0", score_attr_reg[0], 32'h0);
    chk("rst_score1", score_attr_reg[1], 32'h0);
    chk("rst_coin0", coin_attr_reg_out[0], 32'h0);
    chk("rst_coin1", coin_attr_reg_out[1], 32'h0);
    chk("rst_coin2", coin_attr_reg_out[2], 32'h0);
    chk("rst_pulse", {31'b0, collect_pulse}, 32'h0);
    Reset = 1'b0;

    // Basic collection: coin0 val 3 under tank0
    avl_wr(COIN_BASE + 0, mkcoin(1'b1, 100, 100, 0, 3));
    wait_pulse(COIN_NUM + 1, w);
    chk("basic_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("basic_tank", {29'b0, collect_tank}, 32'h0);
    chk("basic_coin", {28'b0, collect_coin}, 32'h0);
    chk("basic_score0", score_attr_reg[0], 32'd3);
    chk("basic_valid", {31'b0, coin_attr_reg_out[0][0]}, 32'h0);
    count_pulses(4, cnt);
    chk("basic_single_pulse", 32'(cnt), 32'd0);

    // Both tanks overlap coin1: tank0 wins
    tank_x[1] = 10'd90; tank_y[1] = 10'd95;
    avl_wr(COIN_BASE + 1, mkcoin(1'b1, 105, 100, 0, 2));
    wait_pulse(COIN_NUM + 1, w);
    chk("tie_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("tie_tank", {29'b0, collect_tank}, 32'h0);
    chk("tie_coin", {28'b0, collect_coin}, 32'h1);
    chk("tie_score0", score_attr_reg[0], 32'd5);
    chk("tie_score1", score_attr_reg[1], 32'd0);

    // Hitbox right edge: x = tank_x+32 misses, reserved bits read 0
    tank_x[1] = 10'd500; tank_y[1] = 10'd500;
    avl_wr(COIN_BASE + 2, mkcoin(1'b1, 112, 100, 0, 1) | 32'hF000_0000);
    chk("edge_rsvd_zero", coin_attr_reg_out[2], mkcoin(1'b1, 112, 100, 0, 1));
    count_pulses(6, cnt);
    chk("edge_miss_pulses", 32'(cnt), 32'd0);
    chk("edge_miss_valid", {31'b0, coin_attr_reg_out[2][0]}, 32'h1);
    chk("edge_miss_score0", score_attr_reg[0], 32'd5);
    // x = tank_x+31 hits
    avl_wr(COIN_BASE + 2, mkcoin(1'b1, 111, 100, 0, 1));
    wait_pulse(COIN_NUM + 1, w);
    chk("edge_hit_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("edge_hit_coin", {28'b0, collect_coin}, 32'h2);
    chk("edge_hit_score0", score_attr_reg[0], 32'd6);
    // Near the right screen edge the box must not wrap
    tank_x[0] = 10'd1000;
    avl_wr(COIN_BASE + 0, mkcoin(1'b1, 1020, 100, 0, 1));
    wait_pulse(COIN_NUM + 1, w);
    chk("wide_hit_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("wide_hit_score0", score_attr_reg[0], 32'd7);

    // Saturation
    avl_wr(SCORE_BASE + 0, 32'hFFFF_FFFE);
    chk("sat_score_wr", score_attr_reg[0], 32'hFFFF_FFFE);
    avl_wr(COIN_BASE + 0, mkcoin(1'b1, 1010, 100, 0, 3));
    wait_pulse(COIN_NUM + 1, w);
    chk("sat_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("sat_score0", score_attr_reg[0], 32'hFFFF_FFFF);
    avl_wr(SCORE_BASE + 1, 32'h0000_1234);
    chk("score1_wr", score_attr_reg[1], 32'h0000_1234);

    // Respawn after 16 cycles; value-0 coin still pulses without scoring
    avl_wr(COIN_BASE + 0, 32'h0);
    avl_wr(COIN_BASE + 1, 32'h0);
    avl_wr(COIN_BASE + 2, 32'h0);
    avl_wr(SCORE_BASE + 0, 32'd100);
    tank_x[0] = 10'd80; tank_y[0] = 10'd90;
    respawn_en = 1'b1;
    avl_wr(COIN_BASE + 1, mkcoin(1'b1, 105, 100, 0, 0));
    wait_pulse(COIN_NUM + 1, w);
    tank_x[0] = 10'd500; tank_y[0] = 10'd300;
    chk("resp_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("resp_coin", {28'b0, collect_coin}, 32'h1);
    chk("val0_score0", score_attr_reg[0], 32'd100);
    for (int i = 0; i < 15; i++) tick();
    chk("resp_still_off", {31'b0, coin_attr_reg_out[1][0]}, 32'h0);
    tick();
    chk("resp_back_on", {31'b0, coin_attr_reg_out[1][0]}, 32'h1);
    chk("resp_x_kept", {22'b0, coin_attr_reg_out[1][10:1]}, 32'd105);
    chk("resp_y_kept", {22'b0, coin_attr_reg_out[1][20:11]}, 32'd100);
    respawn_en = 1'b0;

    // Continuous bus writes hold off a pending collection
    avl_wr(COIN_BASE + 1, 32'h0);
    tank_x[0] = 10'd80; tank_y[0] = 10'd90;
    avl_wr(COIN_BASE + 0, mkcoin(1'b1, 100, 100, 0, 3));
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      avl_wr(SCORE_BASE + 1, 32'h100 + 32'(i));
      if (collect_pulse === 1'b1) cnt++;
    end
    chk("wrhold_no_pulse", 32'(cnt), 32'd0);
    chk("wrhold_score1", score_attr_reg[1], 32'h105);
    chk("wrhold_score0", score_attr_reg[0], 32'd100);
    tick();
    chk("wrhold_release_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("wrhold_release_coin", {28'b0, collect_coin}, 32'h0);
    chk("wrhold_release_score0", score_attr_reg[0], 32'd103);

    // Mid-run reset clears everything at once
    Reset = 1'b1;
    #1;
    chk("mid_rst_score0", score_attr_reg[0], 32'h0);
    chk("mid_rst_score1", score_attr_reg[1], 32'h0);
    chk("mid_rst_coin0", coin_attr_reg_out[0], 32'h0);
    chk("mid_rst_pulse", {31'b0, collect_pulse}, 32'h0);
    tick();
    Reset = 1'b0;

    // Scan restarts at coin 0: coin0 is visited on the 4th edge after release
    avl_wr(COIN_BASE + 0, mkcoin(1'b1, 100, 100, 0, 3));
    avl_wr(COIN_BASE + 2, mkcoin(1'b1, 600, 10, 7, 1));
    avl_wr(COIN_BASE + 1, mkcoin(1'b0, 700, 10, 5, 1));
    chk("sc_restart_early", {31'b0, collect_pulse}, 32'h0);
    tick();
    chk("sc_restart_pulse", {31'b0, collect_pulse}, 32'h1);
    chk("sc_restart_coin", {28'b0, collect_coin}, 32'h0);

    // Animation: prescaler wraps on the 256th edge after release
    for (int i = 0; i < 251; i++) tick();
    chk("anim_before", {29'b0, coin_attr_reg_out[2][23:21]}, 32'd7);
    tick();
    chk("anim_wrap", {29'b0, coin_attr_reg_out[2][23:21]}, 32'd0);
    chk("anim_invalid_kept", {29'b0, coin_attr_reg_out[1][23:21]}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
